// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, captures ROM words into a
// 2-entry queue and hands them to decode over valid/ready.
//
// state   | meaning
// S_RUN   | fetching sequentially from fetchPC while the queue has room
// S_FAULT | fetch halted after out-of-range PC or misaligned redirect
module fetch_ctrl #(
  parameter int          ROM_BYTES = 64,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] romAddress,
  input  logic [31:0] romData,
  input  logic        redirectValid,
  input  logic [31:0] redirectPC,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outInstr,
  output logic [31:0] outPC,
  output logic        fetchFault
);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);
  localparam logic [1:0]  FULL    = 2'(QDEPTH);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] qpc_q   [2];
  logic [31:0] qinstr_q[2];

  logic        in_range;
  logic        pop;
  logic        enq;
  logic        tail;

  assign in_range   = (pc_q <= LAST_PC);
  assign outValid   = (count_q != 2'd0) && !redirectValid;
  assign pop        = outValid && outReady;
  assign enq        = (state_q == S_RUN) && !redirectValid && in_range &&
                      ((count_q < FULL) || pop);
  // With two slots, (head + count) mod 2 is the tail; when full and popping
  // this lands on the slot being freed, which is exactly what we want.
  assign tail       = head_q ^ count_q[0];

  assign romAddress = pc_q;
  assign fetchFault = (state_q == S_FAULT);
  assign outInstr   = (count_q != 2'd0) ? qinstr_q[head_q] : 32'h0;
  assign outPC      = (count_q != 2'd0) ? qpc_q[head_q]    : 32'h0;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    if (redirectValid) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      pc_d    = redirectPC;
      state_d = (redirectPC[1:0] != 2'b00) ? S_FAULT : S_RUN;
    end else begin
      if (enq) pc_d = pc_q + 32'd4;
      if (state_q == S_RUN && !in_range) state_d = S_FAULT;
      count_d = count_q + 2'(enq) - 2'(pop);
      if (pop) head_d = ~head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  // Payload needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      qpc_q[tail]    <= pc_q;
      qinstr_q[tail] <= romData;
    end
  end

endmodule
